alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_sched_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 40 ++++
 rtl/alu_scheduler.sv | 94 +++++++++
 tb/tb_alu_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_sched_pkg
// Description : Opcode constants and FSM state encoding shared by the ALU
//               scheduler and its arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_GT  = 2'd2;
    localparam logic [1:0] OP_SHR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; pointer remembers the last winner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // 1 means requester 1 won last, so requester 0 wins the first contention
    logic r_last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = r_last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (grant != 2'b00) begin
            r_last <= grant[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_scheduler.sv
//------------------------------------------------------------------------------
// Module      : alu_scheduler
// Description : Arbitrates two requesters onto one external combinational ALU
//               and holds each result until the consumer accepts it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [1:0]     req0_mode,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [1:0]     req1_mode,
    output logic           req1_ready,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [1:0]     alu_mode,
    input  logic [2*W-1:0] alu_out,
    output logic           res_valid,
    output logic [2*W-1:0] res_data,
    output logic           res_id,
    input  logic           res_ready
);

    state_t     r_state;
    logic [1:0] w_grant;
    logic       w_arb_en;

    // Grants are only possible in IDLE, and never while reset is asserted
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .enable (w_arb_en),
        .grant  (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= OP_ADD;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        alu_a    <= w_grant[1] ? req1_a    : req0_a;
                        alu_b    <= w_grant[1] ? req1_b    : req0_b;
                        alu_mode <= w_grant[1] ? req1_mode : req0_mode;
                        res_id   <= w_grant[1];
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_data  <= alu_out;
                    res_valid <= 1'b1;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_scheduler
// Description : Scoreboard bench for alu_scheduler with an external ALU model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]     req0_mode = '0, req1_mode = '0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   alu_a, alu_b;
    logic [1:0]     alu_mode;
    logic [2*W-1:0] alu_out;
    logic           res_valid;
    logic [2*W-1:0] res_data;
    logic           res_id;
    logic           res_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] sb[$];
    int           grant_log[$];

    alu_scheduler #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_mode(req0_mode), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_mode(req1_mode), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_out(alu_out),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        alu_out = '0;
        case (alu_mode)
            2'd0: alu_out = 8'(alu_a) + 8'(alu_b);
            2'd1: alu_out[W-1:0] = alu_a & alu_b;
            2'd2: alu_out[0] = (alu_a > alu_b);
            default: alu_out[W-1:0] = alu_a >> alu_b;
        endcase
    end

    function automatic logic [2*W-1:0] ref_alu(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [1:0] m);
        case (m)
            OP_ADD:  return {4'b0, a} + {4'b0, b};
            OP_AND:  return {4'b0, a & b};
            OP_GT:   return (a > b) ? 8'd1 : 8'd0;
            default: return {4'b0, a >> b};
        endcase
    endfunction

    // Scoreboard: push on accept, pop on result handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready || req1_ready) begin
                checks++;
                if ((req0_ready && req1_ready) || res_valid) begin
                    errors++;
                    $display("FAIL ready_exclusive: r0=%b r1=%b res_valid=%b required one ready and no pending result",
                             req0_ready, req1_ready, res_valid);
                end
            end
            if (req0_ready) begin
                sb.push_back({1'b0, ref_alu(req0_a, req0_b, req0_mode)});
                grant_log.push_back(0);
            end
            if (req1_ready) begin
                sb.push_back({1'b1, ref_alu(req1_a, req1_b, req1_mode)});
                grant_log.push_back(1);
            end
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id=%0d data=%h, required no result", res_id, res_data);
                end else begin
                    logic [2*W:0] exp;
                    exp = sb.pop_front();
                    if ({res_id, res_data} !== exp) begin
                        errors++;
                        $display("FAIL sb_result: got id=%0d data=%h, required id=%0d data=%h",
                                 res_id, res_data, exp[2*W], exp[2*W-1:0]);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || res_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: sb=%0d res_valid=%b, required drained", sb.size(), res_valid);
        end
    endtask

    task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] m);
        int n = 0;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m;
        end
        @(negedge clk);
        while (!(id == 0 ? req0_ready : req1_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req%0d never granted, required a grant", id);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_res_valid();
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL res_timeout: res_valid=0, required 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, res_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready0/ready1/res_valid=%b, required 000",
                     {req0_ready, req1_ready, res_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_mode, res_data, res_id} !== '0) begin
            errors++;
            $display("FAIL reset_data: alu_a=%h alu_b=%h mode=%h res_data=%h id=%b, required all 0",
                     alu_a, alu_b, alu_mode, res_data, res_id);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_add_latency();
        wait_idle();
        @(posedge clk); #1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'hF; req0_mode = OP_ADD;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_accept: req0_ready=%b, required 1 in cycle N", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_n1: res_valid=%b, required 0 at N+1", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h1E || res_id !== 1'b0) begin
            errors++;
            $display("FAIL add_n2: valid=%b data=%h id=%b, required 1 1e 0", res_valid, res_data, res_id);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_release: res_valid=%b, required 0", res_valid);
        end
    endtask

    task automatic test_req1_ops();
        logic [2*W-1:0] exp_d[2] = '{8'h01, 8'h00};
        logic [W-1:0]   av[2] = '{4'h8, 4'h3};
        logic [W-1:0]   bv[2] = '{4'h3, 4'h9};
        logic [1:0]     mv[2] = '{OP_SHR, OP_GT};
        wait_idle();
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_req(1, av[i], bv[i], mv[i]);
            wait_res_valid();
            checks++;
            if (res_data !== exp_d[i] || res_id !== 1'b1) begin
                errors++;
                $display("FAIL req1_op%0d: data=%h id=%b, required %h 1", i, res_data, res_id, exp_d[i]);
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
        res_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
        res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_mode = 2'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_mode = 2'($urandom);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        checks++;
        if (grant_log.size() < 4) begin
            errors++;
            $display("FAIL rr_count: grants=%0d, required >=4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL rr_order%0d: grant=%0d, required %0d", i, grant_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        wait_idle();
        res_ready = 1'b0;
        drive_req(0, 4'h5, 4'hC, OP_AND);
        wait_res_valid();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2; req0_mode = OP_ADD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h04 || res_id !== 1'b0 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%h id=%b ready0=%b, required 1 04 0 0",
                         i, res_valid, res_data, res_id, req0_ready);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: res_valid=%b, required 0", res_valid);
        end
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h1; req1_mode = OP_GT;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_release: req1_ready=%b, required 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_in_hold();
        res_ready = 1'b0;
        drive_req(0, 4'h7, 4'h6, OP_ADD);
        wait_res_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || {alu_a, alu_b, alu_mode, res_data, res_id} !== '0) begin
            errors++;
            $display("FAIL hold_reset: valid=%b alu_a=%h alu_b=%h mode=%h data=%h id=%b, required all 0",
                     res_valid, alu_a, alu_b, alu_mode, res_data, res_id);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_mode = OP_AND;
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2; req1_mode = OP_AND;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_sweep();
        res_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    drive_req(0, 4'(a), 4'(b), 2'(m));
                end
            end
        end
        wait_idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sweep_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_req1_ops();
        test_round_robin();
        test_backpressure();
        test_reset_in_hold();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
